// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding for the bit-serial adder
package serial_adder_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_bit_full_adder.sv
// rtl/serial_adder_bit_full_adder.sv - 1-bit full adder cell (module bit_full_adder)
// Two half-adder stages whose carries are ORed.
module bit_full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic hs1;
   logic hc1;
   logic hc2;

   assign hs1 = a ^ b;
   assign hc1 = a & b;
   assign s   = hs1 ^ ci;
   assign hc2 = hs1 & ci;
   assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one bit per clock
// Optional subtract mode under macro SERIAL_ADDER_SUB_EN (adds port sub).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             bit_s;
   logic             bit_co;
   logic             load;
   logic             last_bit;
   logic [WIDTH-1:0] b_load;
   logic             c_init;

`ifdef SERIAL_ADDER_SUB_EN
   // A - B as A + ~B + 1; the final carry then means "no borrow".
   assign b_load = sub ? ~B : B;
   assign c_init = sub;
`else
   assign b_load = B;
   assign c_init = 1'b0;
`endif

   bit_full_adder u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry),
      .s  (bit_s),
      .co (bit_co)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   assign cy       = carry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            // Back-to-back request skips IDLE entirely.
            if (start) begin
               load     = 1'b1;
               state_nx = ST_RUN;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
      end else if (load) begin
         a_sr  <= A;
         b_sr  <= b_load;
         carry <= c_init;
         cnt   <= '0;
      end else if (state == ST_RUN) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         carry <= bit_co;
         // After WIDTH shifts the first (LSB) result bit reaches sum[0].
         sum   <= {bit_s, sum[WIDTH-1:1]};
         cnt   <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
      logic         c;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cy;

   int checks;
   int failures;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cy    (cy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; start is seen by exactly one rising edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts cycles after the accepting edge until done, sampled at negedges.
   task automatic wait_done(output int cycles, output int busy_cnt, output logic got);
      cycles   = 0;
      busy_cnt = 0;
      got      = 1'b0;
      while (!got && cycles < 30) begin
         @(negedge clk);
         cycles++;
         if (busy) busy_cnt++;
         if (done) got = 1'b1;
      end
   endtask

   task automatic do_add(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec);
      int   cycles;
      int   bcnt;
      logic got;
      @(negedge clk);
      launch(a, b);
      wait_done(cycles, bcnt, got);
      chk({name, "_done_seen"}, 32'(got), 32'd1);
      chk({name, "_latency"}, 32'(cycles), 32'(W + 1));
      chk({name, "_busy_cycles"}, 32'(bcnt), 32'(W));
      chk({name, "_sum"}, 32'(sum), 32'(es));
      chk({name, "_cy"}, 32'(cy), 32'(ec));
   endtask

   vec_t vecs[6];

   initial begin
      int           cycles;
      int           bcnt;
      logic         got;
      logic [W:0]   full;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           done_seen;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      A        = '0;
      B        = '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub      = 1'b0;
`endif

      vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
      vecs[2] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
      vecs[5] = '{8'h80, 8'h7F, 8'hFF, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_sum", 32'(sum), 32'd0);
      chk("reset_cy", 32'(cy), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         do_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
      end

      // Result holds through IDLE
      repeat (4) @(negedge clk);
      chk("hold_sum", 32'(sum), 32'hFF);
      chk("hold_cy", 32'(cy), 32'd0);
      chk("hold_busy", 32'(busy), 32'd0);
      chk("hold_done", 32'(done), 32'd0);

      // Start during RUN is ignored
      @(negedge clk);
      launch(8'h03, 8'h04);
      repeat (2) @(negedge clk);
      @(negedge clk);
      launch(8'hFF, 8'hFF);
      wait_done(cycles, bcnt, got);
      chk("ign_done_seen", 32'(got), 32'd1);
      chk("ign_latency", 32'(cycles + 3), 32'(W + 1));
      chk("ign_sum", 32'(sum), 32'h07);
      chk("ign_cy", 32'(cy), 32'd0);
      @(negedge clk);
      chk("ign_no_rerun", 32'(busy), 32'd0);

      // Back-to-back: start held in DONE
      @(negedge clk);
      launch(8'h0F, 8'h01);
      wait_done(cycles, bcnt, got);
      chk("b2b_first_done", 32'(got), 32'd1);
      chk("b2b_first_sum", 32'(sum), 32'h10);
      launch(8'h80, 8'h80);
      chk("b2b_busy_next", 32'(busy), 32'd1);
      wait_done(cycles, bcnt, got);
      chk("b2b_done_seen", 32'(got), 32'd1);
      chk("b2b_latency", 32'(cycles), 32'(W + 1));
      chk("b2b_busy_cycles", 32'(bcnt), 32'(W));
      chk("b2b_sum", 32'(sum), 32'h00);
      chk("b2b_cy", 32'(cy), 32'd1);

      // Asynchronous reset mid-run
      @(negedge clk);
      launch(8'hF5, 8'h36);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_sum", 32'(sum), 32'd0);
      chk("arst_cy", 32'(cy), 32'd0);
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      chk("arst_no_done", 32'(done_seen), 32'd0);
      do_add("post_reset", 8'h01, 8'h02, 8'h03, 1'b0);

      // Random operands against the arithmetic model
      for (int i = 0; i < 20; i++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         full = {1'b0, ra} + {1'b0, rb};
         do_add($sformatf("rnd%0d", i), ra, rb, full[W-1:0], full[W]);
      end

`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b1;
      do_add("sub_5m3", 8'h05, 8'h03, 8'h02, 1'b1);
      do_add("sub_3m5", 8'h03, 8'h05, 8'hFE, 1'b0);
      for (int i = 0; i < 10; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         do_add($sformatf("rsub%0d", i), ra, rb, W'(ra - rb), (ra >= rb));
      end
      sub = 1'b0;
      do_add("sub0_add", 8'h05, 8'h03, 8'h08, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
